alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, shift amount fixed at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  discard all in-flight operations (branch mispredict/trap).
REQ-005 in_valid  input  1  upstream decode offers an operation.
REQ-006 in_ready  output  1  stage accepts the offered operation this cycle.
REQ-007 in_instr  input  5  operation code from shared instruction-code definitions.
REQ-008 in_a  input  32  operand A (rs1 value).
REQ-009 in_b  input  32  operand B (rs2 value or immediate).
REQ-010 in_rd  input  5  destination register index.
REQ-011 out_valid  output  1  result available to writeback.
REQ-012 out_ready  input  1  writeback consumes the result this cycle.
REQ-013 out_result  output  32  computed result.
REQ-014 out_rd  output  5  destination register index of the result.
REQ-015 out_we  output  1  register-file write enable; high iff out_rd != 0.
REQ-016 out_illegal  output  1  operation code was not a supported ALU code.

Function
REQ-017 Two registered stages SHALL exist: S1 (operand register: instr, a, b, rd, valid) and S2 (result register: result, rd, illegal, valid).
REQ-018 S2 "can load" SHALL equal !s2_valid || out_ready; in_ready SHALL equal !flush && (!s1_valid || (S2 can load)).
REQ-019 S1 SHALL capture inputs when in_valid && in_ready; otherwise S1 SHALL clear valid if it advanced, else hold.
REQ-020 S2 SHALL capture the combinational result of S1 contents when s1_valid && (S2 can load); S2 SHALL clear valid when out_ready with no new load, else hold.
REQ-021 Latency: operation accepted in cycle N SHALL appear with out_valid in cycle N+2 when unstalled; throughput one operation per cycle with out_ready high.
REQ-022 While out_valid && !out_ready, out_result, out_rd, out_we, out_illegal SHALL stay constant.
REQ-023 Operations: ADD a+b, SUB a-b (modulo 2^32, no overflow flag), AND, OR, XOR, SLT signed compare -> 1/0, SLTU unsigned compare -> 1/0, SLL, SRL logical, SRA arithmetic sign-fill.
REQ-024 Shift amount SHALL be b[4:0]; b[31:5] ignored; amount 0 returns a unchanged.
REQ-025 Unsupported instr code SHALL produce result 0 and out_illegal=1 for that operation only.
REQ-026 flush SHALL clear s1_valid and s2_valid at the next edge, take priority over every concurrent capture, and drop a concurrently offered input (in_ready low).
REQ-027 Simultaneous S2 drain and S1 advance SHALL move S1 into S2 with no bubble and no loss.

Reset
REQ-028 While rst is sampled high: s1_valid=0, s2_valid=0, out_result=0, out_rd=0, out_illegal=0; out_we therefore 0; in_ready low during the reset cycle, high the cycle after.
REQ-029 rst SHALL override flush and any handshake in the same cycle; reset mid-stream discards all in-flight operations.

Structure
REQ-030 Operation codes (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA) SHALL live in the shared instruction-code definitions file, not in this module.
REQ-031 Shift operations SHALL be delegated to the existing barrel-shift sub-module (5-bit code, 32-bit value, 5-bit amount in, 32-bit result out); all other operations stay inline.

Verification
REQ-032 ADD a=0xFFFFFFFF b=0x00000002 rd=5, out_ready=1 -> two cycles later out_valid=1, result=0x00000001, out_we=1.
REQ-033 SRA a=0x80000000 b=0x00000024 -> result=0xF8000000 (amount 4); SRL same operands -> 0x08000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0.
REQ-034 Back-to-back stream of 4 ops with out_ready held low 3 cycles -> in_ready drops after S1 and S2 fill, out_* stable, all 4 results delivered in order, none duplicated.
REQ-035 flush asserted with both stages valid and in_valid high -> next cycle out_valid=0, s1 empty, offered op never appears.
REQ-036 rd=0 ADD -> out_we=0, result still correct; unsupported code -> result 0, out_illegal=1, following valid op has out_illegal=0.
REQ-037 rst asserted mid-stream for one cycle -> all outputs at reset values next cycle, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared instruction codes and datapath widths for the integer execute stage.
package alu_exec_stage_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 5;
    localparam int REG_W   = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLT  = 5'd5,
        OP_SLTU = 5'd6,
        OP_SLL  = 5'd7,
        OP_SRL  = 5'd8,
        OP_SRA  = 5'd9
    } alu_op_e;

endpackage

// File: rtl/alu_exec_stage_shift.sv
// Barrel shifter: logical left/right and arithmetic right, zero for non-shift codes.
module alu_exec_stage_shift
    import alu_exec_stage_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [XLEN-1:0]    value,
    input  logic [SHAMT_W-1:0] amount,
    output logic [XLEN-1:0]    result
);

    always_comb begin
        result = '0;
        case (op)
            OP_SLL:  result = value << amount;
            OP_SRL:  result = value >> amount;
            OP_SRA:  result = $unsigned($signed(value) >>> amount);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute: S1 holds operands, S2 holds the result; valid/ready on both sides.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [REG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [REG_W-1:0] out_rd,
    output logic             out_we,
    output logic             out_illegal
);

    logic             s1_valid, s2_valid;
    logic [OP_W-1:0]  s1_instr;
    logic [XLEN-1:0]  s1_a, s1_b;
    logic [REG_W-1:0] s1_rd;
    logic [XLEN-1:0]  s2_result;
    logic [REG_W-1:0] s2_rd;
    logic             s2_illegal;

    logic            s2_can_load, in_fire, s1_adv;
    logic [XLEN-1:0] alu_res, shift_res;
    logic            alu_ill;

    assign s2_can_load = !s2_valid || out_ready;
    assign in_ready    = !rst && !flush && (!s1_valid || s2_can_load);
    assign in_fire     = in_valid && in_ready;
    assign s1_adv      = s1_valid && s2_can_load;

    alu_exec_stage_shift u_shift (
        .op     (s1_instr),
        .value  (s1_a),
        .amount (s1_b[SHAMT_W-1:0]),
        .result (shift_res)
    );

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (s1_instr)
            OP_ADD:  alu_res = s1_a + s1_b;
            OP_SUB:  alu_res = s1_a - s1_b;
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_SLT:  alu_res = {31'd0, $signed(s1_a) < $signed(s1_b)};
            OP_SLTU: alu_res = {31'd0, s1_a < s1_b};
            OP_SLL, OP_SRL, OP_SRA: alu_res = shift_res;
            default: alu_ill = 1'b1;
        endcase
    end

    // Operand register needs no reset: its contents are qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_instr <= in_instr;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_rd    <= in_rd;
        end
    end

    // rst beats flush, flush beats every capture; S2 data holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_rd      <= '0;
            s2_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_fire)     s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;

            if (s1_adv) begin
                s2_valid   <= 1'b1;
                s2_result  <= alu_res;
                s2_rd      <= s1_rd;
                s2_illegal <= alu_ill;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_rd      = s2_rd;
    assign out_illegal = s2_illegal;
    assign out_we      = (s2_rd != '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset, op coverage, backpressure, flush, mid-stream reset.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  in_instr, in_rd, out_rd;
    logic [31:0] in_a, in_b, out_result;
    logic        out_we, out_illegal;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vt[$];
    vec_t bp[$];

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_instr = v.op;
        in_a     = v.a;
        in_b     = v.b;
        in_rd    = v.rd;
        #1;
    endtask

    task automatic expect_out(input string tag, input vec_t v);
        chk({tag, ".valid"},   32'(out_valid),   32'd1);
        chk({tag, ".result"},  out_result,       v.res);
        chk({tag, ".rd"},      32'(out_rd),      32'(v.rd));
        chk({tag, ".we"},      32'(out_we),      32'(v.rd != 5'd0));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(v.ill));
    endtask

    task automatic expect_reset_outs(input string tag);
        chk({tag, ".valid"},   32'(out_valid),   32'd0);
        chk({tag, ".result"},  out_result,       32'd0);
        chk({tag, ".rd"},      32'(out_rd),      32'd0);
        chk({tag, ".we"},      32'(out_we),      32'd0);
        chk({tag, ".illegal"}, 32'(out_illegal), 32'd0);
    endtask

    initial begin
        int snd, rcv, stall_seen;
        vec_t v;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = OP_ADD; in_a = 32'h1234; in_b = 32'h1; in_rd = 5'd3;

        // reset: outputs cleared, in_ready low while rst is high
        tick(); tick();
        expect_reset_outs("rst");
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; in_valid = 1'b0; #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        // ADD wraparound, two-cycle latency
        v = '{op: OP_ADD, a: 32'hFFFF_FFFF, b: 32'h2, rd: 5'd5, res: 32'h1, ill: 1'b0};
        drive(v);
        tick();
        in_valid = 1'b0;
        chk("add.lat1_valid", 32'(out_valid), 32'd0);
        tick();
        expect_out("add", v);
        tick();
        chk("add.drained", 32'(out_valid), 32'd0);

        // full-rate stream of directed vectors
        vt.push_back('{OP_SRA,  32'h8000_0000, 32'h0000_0024, 5'd1,  32'hF800_0000, 1'b0});
        vt.push_back('{OP_SRL,  32'h8000_0000, 32'h0000_0024, 5'd2,  32'h0800_0000, 1'b0});
        vt.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  32'h1,         1'b0});
        vt.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4,  32'h0,         1'b0});
        vt.push_back('{OP_SUB,  32'h0,         32'h1,         5'd5,  32'hFFFF_FFFF, 1'b0});
        vt.push_back('{OP_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd6,  32'h00F0_F000, 1'b0});
        vt.push_back('{OP_OR,   32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd7,  32'hFFF0_FFF0, 1'b0});
        vt.push_back('{OP_XOR,  32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd8,  32'hFF00_0FF0, 1'b0});
        vt.push_back('{OP_SLL,  32'h0000_0001, 32'hFFFF_FFE1, 5'd9,  32'h2,         1'b0});
        vt.push_back('{OP_SRA,  32'h1234_5678, 32'h0000_0020, 5'd10, 32'h1234_5678, 1'b0});
        vt.push_back('{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 5'd11, 32'h0,         1'b0});
        vt.push_back('{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd12, 32'h1,         1'b0});
        vt.push_back('{OP_SRA,  32'h7FFF_FFFF, 32'h0000_001F, 5'd13, 32'h0,         1'b0});
        vt.push_back('{OP_ADD,  32'h3,         32'h4,         5'd0,  32'h7,         1'b0});
        vt.push_back('{5'd31,   32'hDEAD_BEEF, 32'h1,         5'd14, 32'h0,         1'b1});
        vt.push_back('{OP_ADD,  32'h1,         32'h1,         5'd15, 32'h2,         1'b0});
        for (int i = 0; i <= vt.size(); i++) begin
            if (i < vt.size()) begin
                drive(vt[i]);
                chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) expect_out($sformatf("stream%0d", i - 1), vt[i - 1]);
        end
        tick();
        chk("stream.drained", 32'(out_valid), 32'd0);

        // backpressure: out_ready low for the first cycles of a 4-op burst
        bp.push_back('{OP_ADD, 32'd10,   32'd20,  5'd1, 32'd30,   1'b0});
        bp.push_back('{OP_SUB, 32'd100,  32'd1,   5'd2, 32'd99,   1'b0});
        bp.push_back('{OP_XOR, 32'hAA,   32'h55,  5'd3, 32'hFF,   1'b0});
        bp.push_back('{OP_SLL, 32'h1,    32'h4,   5'd4, 32'h10,   1'b0});
        snd = 0; rcv = 0; stall_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 5);
            if (snd < 4) drive(bp[snd]);
            else begin in_valid = 1'b0; #1; end
            if (out_valid) begin
                if (rcv < 4) expect_out($sformatf("bp%0d", rcv), bp[rcv]);
                else chk("bp.extra_valid", 32'(out_valid), 32'd0);
                if (out_ready) rcv++;
            end
            if (in_valid && !in_ready) stall_seen = 1;
            if (in_valid && in_ready) snd++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp.sent",       32'(snd),        32'd4);
        chk("bp.received",   32'(rcv),        32'd4);
        chk("bp.stall_seen", 32'(stall_seen), 32'd1);
        chk("bp.drained",    32'(out_valid),  32'd0);

        // flush with both stages full and a new op on offer
        out_ready = 1'b0;
        drive(bp[0]); tick();
        drive(bp[1]); tick();
        chk("flush.pre_valid", 32'(out_valid), 32'd1);
        drive(bp[2]);
        flush = 1'b1; #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        chk("flush.valid0", 32'(out_valid), 32'd0);
        chk("flush.in_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("flush.valid1", 32'(out_valid), 32'd0);
        tick();
        chk("flush.valid2", 32'(out_valid), 32'd0);

        // single-cycle reset mid-stream
        out_ready = 1'b0;
        drive(bp[3]); tick();
        drive(bp[2]); tick();
        chk("midrst.pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; #1;
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        expect_reset_outs("midrst");
        chk("midrst.in_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("midrst.valid1", 32'(out_valid), 32'd0);
        tick();
        chk("midrst.valid2", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
